// File: rtl/can_tx_mbox_arb.sv
// can_tx_mbox_arb: multi-mailbox transmit scheduler in front of the single-frame
// CAN transmitter. Holds NUM_MBOX frames and launches the pending frame with the
// lowest identifier first (lowest index on ties), reporting per-mailbox completion.
// Optional watchdog: define CAN_TX_WATCHDOG_EN to abandon a frame whose core_done
// never arrives within TIMEOUT_CYC cycles; the frame stays pending and retries.
module can_tx_mbox_arb #(
    parameter int NUM_MBOX    = 4,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [10:0]         wr_id,
    input  logic [3:0]          wr_dlc,
    input  logic [63:0]         wr_data,
    input  logic                abort_en,
    input  logic [IDX_W-1:0]    abort_idx,
    output logic                core_start,
    output logic [10:0]         core_id,
    output logic [3:0]          core_dlc,
    output logic [63:0]         core_data,
    input  logic                core_done,
    output logic [NUM_MBOX-1:0] mbox_pending,
    output logic [NUM_MBOX-1:0] mbox_done,
    output logic                active,
    output logic [IDX_W-1:0]    active_idx,
    output logic                wr_err,
    output logic [15:0]         tx_count,
    output logic                timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Catch inconsistent parameter sets at elaboration time.
    if (IDX_W != $clog2(NUM_MBOX)) begin : g_idx_w_check
        $error("IDX_W must equal clog2(NUM_MBOX)");
    end
    if (TIMEOUT_CYC < 2) begin : g_timeout_check
        $error("TIMEOUT_CYC must be at least 2");
    end

    // Mailbox storage
    logic [10:0]         r_id   [NUM_MBOX];
    logic [3:0]          r_dlc  [NUM_MBOX];
    logic [63:0]         r_data [NUM_MBOX];
    logic [NUM_MBOX-1:0] r_pending;

    // Launch / status registers
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_active;
    logic [IDX_W-1:0]    r_active_idx;
    logic                r_core_start;
    logic [10:0]         r_core_id;
    logic [3:0]          r_core_dlc;
    logic [63:0]         r_core_data;
    logic [NUM_MBOX-1:0] r_mbox_done;
    logic                r_wr_err;
    logic [15:0]         r_tx_count;

    // Request decode
    logic                w_wr_hit_active;
    logic                w_abort_hit_active;
    logic                w_wr_ok;
    logic                w_abort_ok;
    logic                w_wr_err;
    logic [3:0]          w_dlc_sat;

    // Arbitration and FSM strobes
    logic                w_any;
    logic [IDX_W-1:0]    w_win_idx;
    logic [10:0]         w_win_id;
    logic                w_launch;
    logic                w_finish;
    logic                w_expire;
    logic                w_wd_hit;

    // The mailbox in flight is frozen: writes and aborts to it are refused.
    // A write and an abort to the same mailbox in one cycle: the abort wins.
    assign w_wr_hit_active    = r_active && (wr_idx == r_active_idx);
    assign w_abort_hit_active = r_active && (abort_idx == r_active_idx);
    assign w_wr_ok    = wr_en && !w_wr_hit_active && !(abort_en && (abort_idx == wr_idx));
    assign w_abort_ok = abort_en && !w_abort_hit_active;
    assign w_wr_err   = (wr_en && w_wr_hit_active) || (abort_en && w_abort_hit_active);
    assign w_dlc_sat  = (wr_dlc > 4'd8) ? 4'd8 : wr_dlc;

    // Pick the pending mailbox with the lowest id; strict '<' keeps the lowest index on ties.
    // A mailbox being aborted this cycle is excluded so it cannot be launched.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        w_any     = 1'b0;
        w_win_idx = '0;
        w_win_id  = '1;
        for (int i = 0; i < NUM_MBOX; i++) begin
            if (r_pending[i] && !(w_abort_ok && (abort_idx == IDX_W'(i))) &&
                (!w_any || (r_id[i] < w_win_id))) begin
                w_any     = 1'b1;
                w_win_idx = IDX_W'(i);
                w_win_id  = r_id[i];
            end
        end
    end

    // FSM next-state and one-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_finish    = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_launch    = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (core_done) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_wd_hit) begin
                    w_expire    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Mailbox contents: loaded by accepted writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the mailbox array is cleared on reset because reset must return
            // every mailbox register to 0; this forces flops rather than RAM.
            for (int i = 0; i < NUM_MBOX; i++) begin
                r_id[i]   <= '0;
                r_dlc[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_id[wr_idx]   <= wr_id;
            r_dlc[wr_idx]  <= w_dlc_sat;
            r_data[wr_idx] <= wr_data;
        end
    end

    // Pending flags: set by writes, cleared by aborts and by completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            if (w_wr_ok)    r_pending[wr_idx]       <= 1'b1;
            if (w_abort_ok) r_pending[abort_idx]    <= 1'b0;
            if (w_finish)   r_pending[r_active_idx] <= 1'b0;
        end
    end

    // Launch path: latch the winner in IDLE and hold it until the next latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active     <= 1'b0;
            r_active_idx <= '0;
            r_core_start <= 1'b0;
            r_core_id    <= '0;
            r_core_dlc   <= '0;
            r_core_data  <= '0;
        end else begin
            r_core_start <= (r_state == START);
            if (w_launch) begin
                r_active     <= 1'b1;
                r_active_idx <= w_win_idx;
                r_core_id    <= r_id[w_win_idx];
                r_core_dlc   <= r_dlc[w_win_idx];
                r_core_data  <= r_data[w_win_idx];
            end else if (w_finish || w_expire) begin
                r_active <= 1'b0;
            end
        end
    end

    // Completion and error reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mbox_done <= '0;
            r_wr_err    <= 1'b0;
            r_tx_count  <= '0;
        end else begin
            r_mbox_done <= w_finish ? (NUM_MBOX'(1) << r_active_idx) : '0;
            r_wr_err    <= w_wr_err;
            if (w_finish) r_tx_count <= r_tx_count + 16'd1;
        end
    end

`ifdef CAN_TX_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;

    assign w_wd_hit = (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: zeroed in START so the first WAIT_DONE cycle counts as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state == START)          r_wd_cnt <= '0;
            else if (r_state == WAIT_DONE) r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wd_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    assign core_start   = r_core_start;
    assign core_id      = r_core_id;
    assign core_dlc     = r_core_dlc;
    assign core_data    = r_core_data;
    assign mbox_pending = r_pending;
    assign mbox_done    = r_mbox_done;
    assign active       = r_active;
    assign active_idx   = r_active_idx;
    assign wr_err       = r_wr_err;
    assign tx_count     = r_tx_count;

endmodule

// File: tb/tb_can_tx_mbox_arb.sv
// tb_can_tx_mbox_arb: directed self-checking bench for can_tx_mbox_arb (default
// build, watchdog disabled). Inputs change and outputs are sampled on the falling edge.
module tb_can_tx_mbox_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [10:0] wr_id;
    logic [3:0]  wr_dlc;
    logic [63:0] wr_data;
    logic        abort_en;
    logic [1:0]  abort_idx;
    logic        core_start;
    logic [10:0] core_id;
    logic [3:0]  core_dlc;
    logic [63:0] core_data;
    logic        core_done;
    logic [3:0]  mbox_pending;
    logic [3:0]  mbox_done;
    logic        active;
    logic [1:0]  active_idx;
    logic        wr_err;
    logic [15:0] tx_count;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;
    bit ok;

    always #5 clk = ~clk;

    can_tx_mbox_arb #(
        .NUM_MBOX    (4),
        .IDX_W       (2),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_id        (wr_id),
        .wr_dlc       (wr_dlc),
        .wr_data      (wr_data),
        .abort_en     (abort_en),
        .abort_idx    (abort_idx),
        .core_start   (core_start),
        .core_id      (core_id),
        .core_dlc     (core_dlc),
        .core_data    (core_data),
        .core_done    (core_done),
        .mbox_pending (mbox_pending),
        .mbox_done    (mbox_done),
        .active       (active),
        .active_idx   (active_idx),
        .wr_err       (wr_err),
        .tx_count     (tx_count),
        .timeout      (timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic do_write(input logic [1:0] idx, input logic [10:0] id,
                            input logic [3:0] dlc, input logic [63:0] data);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_id   = id;
        wr_dlc  = dlc;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_abort(input logic [1:0] idx);
        abort_en  = 1'b1;
        abort_idx = idx;
        @(negedge clk);
        abort_en = 1'b0;
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    // Bounded wait for core_start; returns on the falling edge where it is high.
    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (core_start) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_id = '0; wr_dlc = '0; wr_data = '0;
        abort_en = 1'b0; abort_idx = '0; core_done = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_start",   64'(core_start),   64'(0));
        check("rst_active",  64'(active),       64'(0));
        check("rst_pending", 64'(mbox_pending), 64'(0));
        check("rst_txcnt",   64'(tx_count),     64'(0));
        check("rst_wrerr",   64'(wr_err),       64'(0));
        check("rst_done",    64'(mbox_done),    64'(0));
        check("rst_id",      64'(core_id),      64'(0));
        check("rst_timeout", 64'(timeout),      64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single frame, launch latency
        do_write(2'd0, 11'h123, 4'd1, 64'hAA);
        check("t1_pend",   64'(mbox_pending), 64'b0001);
        check("t1_lat1",   64'(core_start),   64'(0));
        @(negedge clk);
        check("t1_lat2",   64'(core_start),   64'(0));
        check("t1_active", 64'(active),       64'(1));
        @(negedge clk);
        check("t1_start",  64'(core_start),   64'(1));
        check("t1_id",     64'(core_id),      64'h123);
        check("t1_dlc",    64'(core_dlc),     64'(1));
        check("t1_data",   core_data,         64'hAA);
        check("t1_aidx",   64'(active_idx),   64'(0));
        @(negedge clk);
        check("t1_pulse1", 64'(core_start),   64'(0));

        // Queue two frames while mbox0 is in flight; lower id goes first
        do_write(2'd2, 11'h456, 4'd4, 64'hDEADBEEF);
        do_write(2'd3, 11'h100, 4'd2, 64'h11);
        check("t2_nopreempt_id", 64'(core_id),    64'h123);
        check("t2_nopreempt_ix", 64'(active_idx), 64'(0));
        pulse_done();
        check("t1_mdone",  64'(mbox_done),    64'b0001);
        check("t1_pend0",  64'(mbox_pending), 64'b1100);
        check("t1_txcnt",  64'(tx_count),     64'(1));
        check("t1_idle",   64'(active),       64'(0));
        @(negedge clk);
        check("t1_mdone0", 64'(mbox_done),    64'(0));
        check("t2_lat1",   64'(core_start),   64'(0));
        @(negedge clk);
        check("t2_start",  64'(core_start),   64'(1));
        check("t2_id_a",   64'(core_id),      64'h100);
        check("t2_aidx_a", 64'(active_idx),   64'(3));
        @(negedge clk);
        pulse_done();
        check("t2_mdone_a", 64'(mbox_done),   64'b1000);
        check("t2_txcnt_a", 64'(tx_count),    64'(2));
        wait_start(ok);
        check("t2_start_b", 64'(ok),          64'(1));
        check("t2_id_b",    64'(core_id),     64'h456);
        check("t2_dlc_b",   64'(core_dlc),    64'(4));
        check("t2_data_b",  core_data,        64'hDEADBEEF);
        check("t2_aidx_b",  64'(active_idx),  64'(2));
        @(negedge clk);
        pulse_done();
        check("t2_mdone_b", 64'(mbox_done),   64'b0100);
        check("t2_txcnt_b", 64'(tx_count),   64'(3));
        check("t2_pend",    64'(mbox_pending), 64'(0));

        // Equal ids: lowest index wins; dlc 0xF saturates to 8
        do_write(2'd0, 11'h7FF, 4'd0, 64'h0);
        wait_start(ok);
        check("t3_start0", 64'(ok), 64'(1));
        @(negedge clk);
        do_write(2'd3, 11'h200, 4'd3, 64'h33);
        do_write(2'd1, 11'h200, 4'hF, 64'h11);
        pulse_done();
        wait_start(ok);
        check("t3_start1", 64'(ok),         64'(1));
        check("t3_aidx1",  64'(active_idx), 64'(1));
        check("t3_id1",    64'(core_id),    64'h200);
        check("t3_dlcsat", 64'(core_dlc),   64'(8));
        @(negedge clk);
        pulse_done();
        wait_start(ok);
        check("t3_start3", 64'(ok),         64'(3 > 2));
        check("t3_aidx3",  64'(active_idx), 64'(3));
        check("t3_dlc3",   64'(core_dlc),   64'(3));
        @(negedge clk);
        pulse_done();
        check("t3_txcnt",  64'(tx_count),   64'(6));

        // Rejected write/abort to the active mailbox; abort of a pending one
        do_write(2'd0, 11'h050, 4'd2, 64'h55);
        wait_start(ok);
        check("t4_start", 64'(ok), 64'(1));
        @(negedge clk);
        do_write(2'd2, 11'h060, 4'd1, 64'h66);
        check("t4_pend02",   64'(mbox_pending), 64'b0101);
        check("t4_noerr_wr", 64'(wr_err),       64'(0));
        do_abort(2'd0);
        check("t4_err_abort", 64'(wr_err),       64'(1));
        check("t4_keep_pend", 64'(mbox_pending), 64'b0101);
        do_write(2'd0, 11'h001, 4'd1, 64'h77);
        check("t4_err_write", 64'(wr_err),      64'(1));
        check("t4_id_kept",   64'(core_id),     64'h050);
        do_abort(2'd2);
        check("t4_abort2",    64'(mbox_pending), 64'b0001);
        check("t4_noerr_ab",  64'(wr_err),       64'(0));
        // Same-cycle write and abort to idle mailbox 1: abort wins, no error
        wr_en = 1'b1; wr_idx = 2'd1; wr_id = 11'h010; wr_dlc = 4'd1; wr_data = 64'h1;
        abort_en = 1'b1; abort_idx = 2'd1;
        @(negedge clk);
        wr_en = 1'b0; abort_en = 1'b0;
        check("t4_abort_wins", 64'(mbox_pending), 64'b0001);
        check("t4_same_noerr", 64'(wr_err),       64'(0));
        pulse_done();
        check("t4_mdone",  64'(mbox_done),    64'b0001);
        check("t4_pend0",  64'(mbox_pending), 64'(0));
        check("t4_txcnt",  64'(tx_count),     64'(7));
        wait_start(ok);
        check("t4_no_launch", 64'(ok), 64'(0));

        // Reset during WAIT_DONE drops the frame silently
        do_write(2'd1, 11'h0AA, 4'd1, 64'h1);
        wait_start(ok);
        check("t5_start", 64'(ok), 64'(1));
        @(negedge clk);
        do_write(2'd2, 11'h0BB, 4'd1, 64'h2);
        rst = 1'b1;
        @(negedge clk);
        check("t5_active",  64'(active),       64'(0));
        check("t5_pending", 64'(mbox_pending), 64'(0));
        check("t5_id",      64'(core_id),      64'(0));
        check("t5_data",    core_data,         64'(0));
        check("t5_txcnt",   64'(tx_count),     64'(0));
        rst = 1'b0;
        @(negedge clk);
        pulse_done();
        check("t5_no_mdone", 64'(mbox_done), 64'(0));
        check("t5_txcnt2",   64'(tx_count),  64'(0));
        wait_start(ok);
        check("t5_no_launch", 64'(ok), 64'(0));

        // Normal operation after reset
        do_write(2'd2, 11'h3FF, 4'd9, 64'h0123456789ABCDEF);
        wait_start(ok);
        check("t6_start", 64'(ok),        64'(1));
        check("t6_id",    64'(core_id),   64'h3FF);
        check("t6_dlc",   64'(core_dlc),  64'(8));
        check("t6_data",  core_data,      64'h0123456789ABCDEF);
        @(negedge clk);
        pulse_done();
        check("t6_mdone", 64'(mbox_done), 64'b0100);
        check("t6_txcnt", 64'(tx_count),  64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
